// File: rtl/lsu_mem_port_if.sv
// Request/response and RAM-side signal bundle for the load/store unit.
// slave is the LSU's view; master is the core+RAM side.
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_fault,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_fault,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: byte/half/word access to a synchronous RAM
// with lane enables, load extension and alignment faults.
module lsu_mem_port #(
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    lsu_mem_port_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

    state_t            state_q;
    logic              ready_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [1:0]        cnt_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_fault_q;
    logic              mem_en_q;
    logic [3:0]        mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              legal_d;
    logic              fault_d;
    logic              half_d;
    logic              word_d;
    logic [1:0]        off_d;
    logic [3:0]        we_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       lane_d;
    logic [31:0]       ext_d;

    assign off_d  = bus.req_addr[1:0];
    assign half_d = bus.req_funct3[1:0] == 2'b01;
    assign word_d = bus.req_funct3[1:0] == 2'b10;
    assign addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        legal_d = 1'b0;
        unique case (bus.req_funct3)
            3'b000,
            3'b001,
            3'b010:  legal_d = 1'b1;
            3'b100,
            3'b101:  legal_d = !bus.req_we;
            default: legal_d = 1'b0;
        endcase
    end

    assign fault_d = !legal_d
                   || (half_d && off_d[0])
                   || (word_d && off_d != 2'b00);

    // Lane placement; store data is replicated so any lane sees it.
    always_comb begin
        we_d    = 4'b0000;
        wdata_d = bus.req_wdata;
        if (bus.req_funct3[1:0] == 2'b00) begin
            wdata_d = {4{bus.req_wdata[7:0]}};
            we_d    = 4'b0001 << off_d;
        end else if (half_d) begin
            wdata_d = {2{bus.req_wdata[15:0]}};
            we_d    = 4'b0011 << off_d;
        end else begin
            we_d    = 4'b1111;
        end
        if (!bus.req_we) begin
            we_d = 4'b0000;
        end
    end

    assign lane_d = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_d = lane_d;
        unique case (f3_q)
            3'b000:  ext_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b001:  ext_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b100:  ext_d = {24'd0, lane_d[7:0]};
            3'b101:  ext_d = {16'd0, lane_d[15:0]};
            default: ext_d = lane_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_fault_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        off_q   <= off_d;
                        if (fault_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            state_q     <= ISSUE;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= we_d;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 4'b0000;
                    if (we_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= LAT_M1;
                    end
                end
                WAIT: begin
                    // Last WAIT cycle is ISSUE+MEM_LATENCY: RAM data valid.
                    if (cnt_q == 2'b00) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_rdata_q <= ext_d;
                    end else begin
                        cnt_q <= cnt_q - 2'b01;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: two instances (RAM latency 1 and 3)
// each backed by a small behavioural RAM.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_W(32)) a ();
    lsu_mem_port_if #(.ADDR_W(32)) b ();

    lsu_mem_port #(.ADDR_W(32), .MEM_LATENCY(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );
    lsu_mem_port #(.ADDR_W(32), .MEM_LATENCY(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    logic [31:0] ram_a [0:63];
    logic [31:0] ram_b [0:63];
    logic [31:0] pa;
    logic [31:0] pb0, pb1, pb2;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram_a[i] <= 32'd0;
            pa <= 32'd0;
        end else if (a.mem_en) begin
            for (int i = 0; i < 4; i++)
                if (a.mem_we[i]) ram_a[a.mem_addr[7:2]][i*8 +: 8] <= a.mem_wdata[i*8 +: 8];
            pa <= ram_a[a.mem_addr[7:2]];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram_b[i] <= 32'd0;
            pb0 <= 32'd0;
            pb1 <= 32'd0;
            pb2 <= 32'd0;
        end else begin
            if (b.mem_en) begin
                for (int i = 0; i < 4; i++)
                    if (b.mem_we[i]) ram_b[b.mem_addr[7:2]][i*8 +: 8] <= b.mem_wdata[i*8 +: 8];
                pb0 <= ram_b[b.mem_addr[7:2]];
            end
            pb1 <= pb0;
            pb2 <= pb1;
        end
    end

    assign a.mem_rdata = pa;
    assign b.mem_rdata = pb2;

    logic        sel;
    logic        o_en, o_ready, o_rv, o_fault;
    logic [3:0]  o_we;
    logic [31:0] o_addr, o_wd, o_rd;
    assign o_en    = sel ? b.mem_en    : a.mem_en;
    assign o_ready = sel ? b.req_ready : a.req_ready;
    assign o_rv    = sel ? b.rsp_valid : a.rsp_valid;
    assign o_fault = sel ? b.rsp_fault : a.rsp_fault;
    assign o_we    = sel ? b.mem_we    : a.mem_we;
    assign o_addr  = sel ? b.mem_addr  : a.mem_addr;
    assign o_wd    = sel ? b.mem_wdata : a.mem_wdata;
    assign o_rd    = sel ? b.rsp_rdata : a.rsp_rdata;

    int checks = 0;
    int errors = 0;

    int          r_lat, r_en_n;
    logic [3:0]  r_we;
    logic [31:0] r_addr, r_wd, r_rd;
    logic        r_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic we,
                         input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
        if (s) begin
            b.req_valid = v; b.req_we = we; b.req_funct3 = f3;
            b.req_addr = ad; b.req_wdata = wd;
        end else begin
            a.req_valid = v; a.req_we = we; a.req_funct3 = f3;
            a.req_addr = ad; a.req_wdata = wd;
        end
    endtask

    task automatic run(input logic s, input logic we, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd);
        bit done;
        done = 0;
        @(negedge clk);
        sel = s;
        #1;
        check("ready_pre", {31'd0, o_ready}, 32'd1);
        drive(s, 1'b1, we, f3, ad, wd);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        r_lat = 0; r_en_n = 0; r_we = 4'h0; r_addr = 32'd0;
        r_wd = 32'd0; r_rd = 32'hx; r_fault = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (o_en) begin
                r_en_n++;
                r_we = o_we; r_addr = o_addr; r_wd = o_wd;
            end
            if (o_rv) begin
                r_lat = n; r_rd = o_rd; r_fault = o_fault;
                done = 1;
                break;
            end
        end
        if (!done) check("rsp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("rv_pulse", {31'd0, o_rv}, 32'd0);
        check("ready_back", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic chk_store(input string t, input logic [3:0] we, input logic [31:0] ad,
                             input logic [31:0] wd);
        check({t, "_we"}, {28'd0, r_we}, {28'd0, we});
        check({t, "_addr"}, r_addr, ad);
        check({t, "_wd"}, r_wd, wd);
        check({t, "_lat"}, r_lat, 32'd2);
        check({t, "_en_n"}, r_en_n, 32'd1);
        check({t, "_fault"}, {31'd0, r_fault}, 32'd0);
        check({t, "_rd"}, r_rd, 32'd0);
    endtask

    task automatic chk_load(input string t, input logic [31:0] rd, input int lat);
        check({t, "_rd"}, r_rd, rd);
        check({t, "_lat"}, r_lat, lat);
        check({t, "_en_n"}, r_en_n, 32'd1);
        check({t, "_we"}, {28'd0, r_we}, 32'd0);
        check({t, "_fault"}, {31'd0, r_fault}, 32'd0);
    endtask

    task automatic chk_fault(input string t);
        check({t, "_fault"}, {31'd0, r_fault}, 32'd1);
        check({t, "_lat"}, r_lat, 32'd1);
        check({t, "_en_n"}, r_en_n, 32'd0);
        check({t, "_rd"}, r_rd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        sel = 1'b0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, a.req_ready}, 32'd1);
        check("rst_rv", {31'd0, a.rsp_valid}, 32'd0);
        check("rst_rd", a.rsp_rdata, 32'd0);
        check("rst_fault", {31'd0, a.rsp_fault}, 32'd0);
        check("rst_en", {31'd0, a.mem_en}, 32'd0);
        check("rst_we", {28'd0, a.mem_we}, 32'd0);
        check("rst_addr", a.mem_addr, 32'd0);
        check("rst_wd", a.mem_wdata, 32'd0);
        reset = 1'b0;

        run(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk_store("sw", 4'hF, 32'h10, 32'hDEADBEEF);
        run(0, 1, 3'b000, 32'h13, 32'h000000A5);
        chk_store("sb", 4'b1000, 32'h10, 32'hA5A5A5A5);
        run(0, 0, 3'b100, 32'h13, 32'd0);
        chk_load("lbu13", 32'h000000A5, 3);
        run(0, 0, 3'b010, 32'h10, 32'd0);
        chk_load("lw_after_sb", 32'hA5ADBEEF, 3);

        run(0, 1, 3'b010, 32'h10, 32'h8000F0F0);
        chk_store("sw2", 4'hF, 32'h10, 32'h8000F0F0);
        run(0, 0, 3'b001, 32'h12, 32'd0);
        chk_load("lh12", 32'hFFFF8000, 3);
        run(0, 0, 3'b101, 32'h12, 32'd0);
        chk_load("lhu12", 32'h00008000, 3);
        run(0, 0, 3'b000, 32'h10, 32'd0);
        chk_load("lb10", 32'hFFFFFFF0, 3);
        run(0, 0, 3'b000, 32'h11, 32'd0);
        chk_load("lb11", 32'hFFFFFFF0, 3);
        run(0, 0, 3'b101, 32'h10, 32'd0);
        chk_load("lhu10", 32'h0000F0F0, 3);
        run(0, 1, 3'b001, 32'h12, 32'hFFFF1234);
        chk_store("sh12", 4'b1100, 32'h10, 32'h12341234);
        run(0, 0, 3'b010, 32'h10, 32'd0);
        chk_load("lw_after_sh", 32'h1234F0F0, 3);
        run(0, 0, 3'b100, 32'h12, 32'd0);
        chk_load("lbu12", 32'h00000034, 3);

        run(0, 0, 3'b010, 32'h11, 32'd0);
        chk_fault("lw11");
        run(0, 1, 3'b001, 32'h13, 32'h1234);
        chk_fault("sh13");
        run(0, 0, 3'b011, 32'h10, 32'd0);
        chk_fault("ld011");
        run(0, 1, 3'b100, 32'h10, 32'd0);
        chk_fault("st100");
        run(0, 0, 3'b101, 32'h11, 32'd0);
        chk_fault("lhu11");
        run(0, 0, 3'b000, 32'h12, 32'd0);
        chk_load("lb12_after_fault", 32'h00000034, 3);

        run(0, 1, 3'b010, 32'hFFFFFFFC, 32'h11223344);
        chk_store("sw_top", 4'hF, 32'hFFFFFFFC, 32'h11223344);
        run(0, 1, 3'b000, 32'hFFFFFFFE, 32'h00000077);
        chk_store("sb_top", 4'b0100, 32'hFFFFFFFC, 32'h77777777);
        run(0, 0, 3'b010, 32'hFFFFFFFC, 32'd0);
        chk_load("lw_top", 32'h11773344, 3);

        run(1, 1, 3'b010, 32'h20, 32'h12345678);
        chk_store("b_sw", 4'hF, 32'h20, 32'h12345678);
        run(1, 0, 3'b010, 32'h20, 32'd0);
        chk_load("b_lw", 32'h12345678, 5);
        run(1, 0, 3'b001, 32'h22, 32'd0);
        chk_load("b_lh", 32'h00001234, 5);

        @(negedge clk);
        sel = 1'b1;
        #1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_en", {31'd0, o_en}, 32'd0);
        check("abort_we", {28'd0, o_we}, 32'd0);
        check("abort_rv", {31'd0, o_rv}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_rv) pulses++;
        end
        check("abort_norsp", pulses, 32'd0);
        check("abort_ready2", {31'd0, o_ready}, 32'd1);
        run(1, 1, 3'b010, 32'h20, 32'hCAFEF00D);
        chk_store("b_sw2", 4'hF, 32'h20, 32'hCAFEF00D);
        run(1, 0, 3'b000, 32'h21, 32'd0);
        chk_load("b_lb21", 32'hFFFFFFF0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
